// File: rtl/pwm_duty_arbiter_if.sv
// pwm_duty_arbiter_if: requester valid/ready bus into the PWM duty arbiter
interface pwm_duty_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int DUTY_W = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*DUTY_W-1:0] req_duty;
  logic [N_REQ-1:0] req_stop;
  logic [N_REQ-1:0] req_ready;
  modport master(output req_valid, req_duty, req_stop, input req_ready);
  modport slave(input req_valid, req_duty, req_stop, output req_ready);
endinterface

// File: rtl/pwm_duty_arbiter.sv
// pwm_duty_arbiter: round-robin enable/duty updates applied only on PWM period boundaries
module pwm_duty_arbiter #(
  parameter int N_REQ = 2,
  parameter int DUTY_W = 2,
  parameter int PERIOD = 10
) (
  input  logic clk,
  input  logic reset,
  pwm_duty_arbiter_if.slave bus,
  output logic pwm_en,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic period_start,
  output logic busy,
  output logic [N_REQ-1:0] last_grant
);
  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(PERIOD);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state;
  logic [HW-1:0] phase, phase_n;
  logic [PW-1:0] ptr, gi, idx;
  logic gnt, g_stop, sh_stop, wrap, app, app_stop, en_n;
  logic [DUTY_W-1:0] g_duty, sh_duty, app_duty;
  logic [N_REQ-1:0] ready, sh_own, app_own;
  always_comb begin
    gi = '0;
    idx = '0;
    gnt = 1'b0;
    g_duty = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (bus.req_valid[idx]) begin
        gi = idx;
        gnt = state != PEND;
      end
    end
    for (int i = 0; i < N_REQ; i++)
      if (gi == PW'(i)) g_duty = bus.req_duty[i*DUTY_W +: DUTY_W];
    ready = gnt ? N_REQ'(1) << gi : '0;
  end
  assign bus.req_ready = ready;
  assign g_stop = bus.req_stop[gi];
  assign wrap = phase == HW'(PERIOD - 1);
  // Updates land only at the wrap, either from the shadow or a grant taken on the last phase
  assign app = wrap && (state == PEND || (state == RUN && gnt));
  assign app_stop = state == PEND ? sh_stop : g_stop;
  assign app_duty = state == PEND ? sh_duty : g_duty;
  assign app_own = state == PEND ? sh_own : ready;
  assign phase_n = (state == IDLE || wrap) ? '0 : phase + HW'(1);
  assign en_n = state == IDLE ? gnt && !g_stop : !(app && app_stop);
  assign busy = state == PEND;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= '0;
      ptr <= '0;
      sh_duty <= '0;
      sh_stop <= 1'b0;
      sh_own <= '0;
      pwm_en <= 1'b0;
      pwm_duty <= '0;
      period_start <= 1'b0;
      last_grant <= '0;
    end else begin
      phase <= phase_n;
      pwm_en <= en_n;
      period_start <= en_n && phase_n == '0;
      if (gnt) ptr <= PW'((int'(gi) + 1) % N_REQ);
      if (state == IDLE && gnt && !g_stop) begin
        state <= RUN;
        pwm_duty <= g_duty;
        last_grant <= ready;
      end else if (app) begin
        state <= app_stop ? IDLE : RUN;
        if (!app_stop) pwm_duty <= app_duty;
        last_grant <= app_own;
      end else if (state == RUN && gnt) begin
        state <= PEND;
        sh_duty <= g_duty;
        sh_stop <= g_stop;
        sh_own <= ready;
      end
    end
  end
endmodule

// File: doc/pwm_duty_arbiter.md
# pwm_duty_arbiter

Arbitrated configuration controller for the single-channel PWM generator. Multiple requesters (fan control, LED dimming, software register) submit enable/duty updates over valid/ready. The block grants them round-robin and drives the PWM enable and duty-cycle inputs. Duty changes are applied only on a PWM period boundary, so the output never contains a truncated or glitched period.

## Interface
- N_REQ, 2: number of requesters, legal 2..4
- DUTY_W, 2: duty-cycle width, matching the PWM duty input
- PERIOD, 10: PWM period in clk cycles, which must equal the generator's counter wrap (0..PERIOD-1)
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  per-requester request
- req_duty  in  N_REQ*DUTY_W  requester i duty at [i*DUTY_W +: DUTY_W]
- req_stop  in  N_REQ  requester i asks to disable the PWM; req_duty[i] is ignored
- req_ready  out  N_REQ  one-hot accept, combinational from req_valid, state and pointer
- pwm_en  out  1  registered enable to the PWM generator
- pwm_duty  out  DUTY_W  registered duty to the PWM generator
- period_start  out  1  registered pulse, high when phase==0 and pwm_en==1
- busy  out  1  high in PEND (an accepted update is waiting for the boundary)
- last_grant  out  N_REQ  one-hot requester of the most recently applied update

## Operation
- Internal phase counter: 0..PERIOD-1, mirrors the generator.
  - Held at 0 in IDLE.
  - Increments in RUN/PEND and wraps PERIOD-1 -> 0.
- Round-robin pointer, reset 0. Search order: pointer, pointer+1, … mod N_REQ. After a grant to i, pointer = (i+1) mod N_REQ.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requesters hold valid/duty/stop stable until ready. Ready never asserts in PEND.
- FSM states IDLE, RUN, PEND:
  - IDLE, granted start (stop=0): next cycle pwm_en=1, pwm_duty=req_duty, phase=0, -> RUN.
  - IDLE, granted stop: accepted, no output change, stay IDLE.
  - RUN, grant with phase != PERIOD-1: latch duty/stop into a shadow register, -> PEND.
  - RUN, grant with phase == PERIOD-1: apply directly at the wrap. Stop -> IDLE with pwm_en=0; start -> new pwm_duty, stay RUN.
  - PEND, phase == PERIOD-1: apply the shadow at the wrap as above; PEND -> RUN or IDLE.
- Applying an update sets last_grant to the owner's one-hot.
- A new duty equal to the current duty is still a full transaction: accepted, applied, last_grant updated.

## Timing
- Reset values: pwm_en=0, pwm_duty=0, period_start=0, busy=0, last_grant=0, req_ready=0, pointer=0, phase=0, shadow cleared, state IDLE.
- Accept-to-apply latency:
  - From IDLE: 1 cycle.
  - From RUN/PEND: the update lands on the first cycle with phase==0 after acceptance, which is 1..PERIOD cycles later.
- period_start is high in the same cycle as phase==0, including the first cycle after an IDLE start.
- Simultaneous requests: exactly one ready per cycle. Losers keep valid asserted and are served in later grants, with no starvation beyond N_REQ-1 grants.
- Requests arriving during PEND are stalled until after the boundary, with at most one pending update.
- Reset during PEND: the pending update is discarded and its requester is not re-acked.
- A stop applied at the wrap makes pwm_en fall on the cycle phase would return to 0. The last period completes in full.

## Test plan
- Reset, then req_valid[0]=1, duty=2, stop=0 -> ready[0] same cycle; next cycle pwm_en=1, pwm_duty=2, period_start=1, last_grant=01.
- Running at duty 2, req 1 sends duty=1 at phase 3 -> busy=1 for phases 4..9; pwm_duty changes to 1 exactly when phase returns to 0; busy clears.
- Both requesters valid continuously with distinct duties -> grants alternate 0,1,0,1; at most one update is applied per period.
- Running, req 0 sends stop at phase 9 -> applied at the immediate wrap; pwm_en=0 next cycle, state IDLE, no busy pulse.
- Update accepted at phase 5, reset asserted at phase 7 -> all outputs return to reset values, pending duty is never applied, and pointer=0.
- From IDLE, req_stop[1] -> ready[1], pwm_en stays 0, last_grant stays 00, next grant priority starts at requester 0.
